shift_mult_ctrl: RTL and testbench

- Sequencing FSM for the add-shift signed multiplier datapath: A and B 8-bit shift registers, X sign flop, 9-bit adder/subtractor.
- Takes the user Run and ClearA_LoadB controls plus the multiplier LSB M.
- Emits per-cycle Clear_A, Ld_B, Add, Sub and Shift_En strobes to run one WIDTH-iteration signed multiply per Run press.
- Sits between the debounced switch/button inputs and the register/adder datapath.

---
 rtl/shift_mult_pkg.sv | 21 ++
 rtl/mult_iter_counter.sv | 31 +++
 rtl/shift_mult_ctrl.sv | 119 +++++++++++
 tb/tb_shift_mult_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_mult_pkg.sv
// Shared types and constants for the add-shift signed multiplier controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package shift_mult_pkg;

  // Default operand width and number of add/shift iterations.
  localparam int WIDTH_DEF = 8;

  // Run-sampled to first Done cycle with fixed ADD/SHIFT alternation:
  // one CLEAR, WIDTH ADD/SHIFT pairs, then the first HOLD cycle.
  localparam int FIXED_LATENCY = 1 + 2 * WIDTH_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter: clears to zero, increments, flags the final iteration.
// Latency: Count updates one cycle after Clr/Inc; Last is combinational on Count.
// Backpressure: none; Inc is ignored once Last is set, so Count never wraps.
module mult_iter_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Clr,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count,
  output logic             Last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  // Counter register: reset and Clr load zero, Inc steps until the last index.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (Inc && !Last) begin
      Count <= Count + 1'b1;
    end
  end

  assign Last = (Count == LAST_VAL);

endmodule

// File: rtl/shift_mult_ctrl.sv
// Sequencer for the add-shift signed multiplier; build option SHIFT_MULT_SKIP_ZERO_EN skips ADD when M = 0.
// Latency: Run sampled -> first Done cycle is 2*WIDTH+2 cycles (2+WIDTH+popcount(B) with the skip option).
// Backpressure: none; a started multiply always completes, Done holds until Run returns low.
module shift_mult_ctrl
  import shift_mult_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             M,
  output logic             Clear_A,
  output logic             Ld_B,
  output logic             Add,
  output logic             Sub,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Iter
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  ctrl_state_t step_state;
  logic        iter_clr;
  logic        iter_inc;
  logic        iter_last;

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr     (iter_clr),
    .Inc     (iter_inc),
    .Count   (Iter),
    .Last    (iter_last)
  );

  // State entered at the start of each iteration. With the skip option the
  // datapath already presents the upcoming multiplier bit on M, so a zero bit
  // goes straight to SHIFT.
`ifdef SHIFT_MULT_SKIP_ZERO_EN
  assign step_state = M ? ST_ADD : ST_SHIFT;
`else
  assign step_state = ST_ADD;
`endif

  // State register; reset overrides everything, including a running multiply.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode from state, Iter and M.
  always_comb begin
    state_nxt = state;
    Clear_A   = 1'b0;
    Ld_B      = 1'b0;
    Add       = 1'b0;
    Sub       = 1'b0;
    Shift_En  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    iter_clr  = 1'b0;
    iter_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Run has priority: B must not be reloaded from the multiplicand switches.
        Clear_A = ClearA_LoadB & ~Run;
        Ld_B    = ClearA_LoadB & ~Run;
        if (Run) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        Busy      = 1'b1;
        Clear_A   = 1'b1;
        iter_clr  = 1'b1;
        state_nxt = step_state;
      end
      ST_ADD: begin
        Busy = 1'b1;
        // The sign bit of a two's complement multiplier carries negative weight.
        Add       = M & ~iter_last;
        Sub       = M & iter_last;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (iter_last) begin
          state_nxt = ST_HOLD;
        end else begin
          iter_inc  = 1'b1;
          state_nxt = step_state;
        end
      end
      ST_HOLD: begin
        // Waiting for Run to drop keeps one held press to a single multiply.
        Done = 1'b1;
        if (!Run) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Bench for shift_mult_ctrl: drives a behavioural A/X/B datapath from the DUT strobes.
// Expected product/latency/add pattern per multiply go to a scoreboard queue.
// A negedge monitor pops and compares at each first Done.
module tb_shift_mult_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       Clear_A;
  logic       Ld_B;
  logic       Add;
  logic       Sub;
  logic       Shift_En;
  logic       Busy;
  logic       Done;
  logic [2:0] Iter;

  shift_mult_ctrl #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clear_A      (Clear_A),
    .Ld_B         (Ld_B),
    .Add          (Add),
    .Sub          (Sub),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done),
    .Iter         (Iter)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- datapath model (switches, A, X, B) ----------------
  logic [7:0] sw    = 8'h00;
  logic [7:0] a_reg = 8'h00;
  logic [7:0] b_reg = 8'h00;
  logic       x_reg = 1'b0;

  always @(posedge Clk) begin
    if (Ld_B) b_reg <= sw;
    if (Clear_A) begin
      a_reg <= 8'h00;
      x_reg <= 1'b0;
    end else if (Add) begin
      {x_reg, a_reg} <= {a_reg[7], a_reg} + {sw[7], sw};
    end else if (Sub) begin
      {x_reg, a_reg} <= {a_reg[7], a_reg} - {sw[7], sw};
    end else if (Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

`ifdef SHIFT_MULT_SKIP_ZERO_EN
  assign M = Shift_En ? b_reg[1] : b_reg[0];
`else
  assign M = b_reg[0];
`endif

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] prod;
    int          lat;
    logic [7:0]  add_mask;
    int          n_sub;
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t make_exp(input logic [7:0] s, input logic [7:0] b);
    exp_t e;
    int   p;
    p          = $signed(s) * $signed(b);
    e.prod     = p[15:0];
`ifdef SHIFT_MULT_SKIP_ZERO_EN
    e.lat      = 2 + 8 + $countones(b);
`else
    e.lat      = 1 + 2 * 8 + 1;
`endif
    e.add_mask = {1'b0, b[6:0]};
    e.n_sub    = int'(b[7]);
    return e;
  endfunction

  // ---------------- monitor ----------------
  bit         in_op    = 1'b0;
  int         cyc      = 0;
  int         st_cyc   = 0;
  int         mon_sh   = 0;
  int         mon_sub  = 0;
  logic [7:0] mon_mask = 8'h00;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Reset_n !== 1'b1) begin
        in_op = 1'b0;
        sb_q.delete();
      end else begin
        if (Add || Sub) chk("add_sub_exclusive", {31'd0, Add & Sub}, 32'd0);
        if (Busy && !in_op) begin
          chk("op_expected", {31'd0, sb_q.size() > 0}, 32'd1);
          in_op    = 1'b1;
          st_cyc   = cyc;
          mon_sh   = 0;
          mon_sub  = 0;
          mon_mask = 8'h00;
        end
        if (in_op) begin
          if (Add) mon_mask[Iter] = 1'b1;
          if (Sub) begin
            mon_sub++;
            chk("sub_on_last_iter", Iter, 32'd7);
          end
          if (Shift_En) mon_sh++;
          if (Done) begin
            in_op = 1'b0;
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              chk("product", {a_reg, b_reg}, e.prod);
              chk("latency", cyc - st_cyc + 1, e.lat);
              chk("add_iterations", mon_mask, e.add_mask);
              chk("sub_count", mon_sub, e.n_sub);
              chk("shift_count", mon_sh, 32'd8);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] b);
    sw           = b;
    ClearA_LoadB = 1'b1;
    #1;
    chk("idle_ld_b", Ld_B, 32'd1);
    chk("idle_clear_a", Clear_A, 32'd1);
    tick();
    ClearA_LoadB = 1'b0;
  endtask

  // Issue one multiply of s by the already-loaded b; hold keeps Run high that
  // many extra cycles after Done; clb keeps ClearA_LoadB high during the Run cycle.
  task automatic start_mult(input logic [7:0] s, input logic [7:0] b, input int hold, input bit clb);
    int n;
    sb_q.push_back(make_exp(s, b));
    sw           = s;
    Run          = 1'b1;
    ClearA_LoadB = clb;
    #1;
    if (clb) chk("run_wins_no_ld_b", Ld_B, 32'd0);
    tick();
    chk("busy_after_run", Busy, 32'd1);
    ClearA_LoadB = 1'b0;
    if (hold == 0) Run = 1'b0;
    n = 0;
    while (!Done && n < 100) begin
      tick();
      n++;
    end
    chk("done_seen", Done, 32'd1);
    if (hold > 0) begin
      repeat (hold) tick();
      chk("done_held", Done, 32'd1);
      chk("no_restart_while_held", Busy, 32'd0);
      Run = 1'b0;
    end
    tick();
    chk("idle_after_done", {Done, Busy}, 32'd0);
  endtask

  initial begin : stim
    exp_t dummy;
    int   n;
    logic [7:0] rs;
    logic [7:0] rb;
    dummy        = make_exp(8'h00, 8'h00);
    Reset_n      = 1'b0;
    Run          = 1'b1;
    ClearA_LoadB = 1'b0;

    // Reset with Run high: nothing starts.
    repeat (2) tick();
    chk("rst_strobes", {Clear_A, Ld_B, Add, Sub, Shift_En, Busy, Done}, 32'd0);
    chk("rst_iter", Iter, 32'd0);

    // Releasing reset with Run still high enters CLEAR on the next edge.
    sb_q.push_back(dummy);
    Reset_n = 1'b1;
    tick();
    chk("clear_after_release", {Busy, Clear_A}, 32'd3);
    Run     = 1'b0;
    Reset_n = 1'b0;
    tick();
    chk("abort_busy", Busy, 32'd0);
    Reset_n = 1'b1;
    tick();

    // ClearA_LoadB held in IDLE, then Run with it still high.
    sw           = 8'h03;
    ClearA_LoadB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("clb_held_strobes", {Clear_A, Ld_B, Busy}, 32'd6);
      tick();
    end
    start_mult(8'h05, 8'h03, 0, 1'b1);

    // Only the sign bit of the multiplier set: one Sub, no Add.
    load_b(8'h80);
    start_mult(8'h07, 8'h80, 0, 1'b0);

    // Run held long: one multiply, Done held, then a fresh Run restarts.
    load_b(8'hA5);
    start_mult(8'hF3, 8'hA5, 40, 1'b0);
    load_b(8'h03);
    start_mult(8'h9C, 8'h03, 0, 1'b0);

    // Reset in the middle of iteration 4.
    load_b(8'h5A);
    sb_q.push_back(dummy);
    sw  = 8'h11;
    Run = 1'b1;
    tick();
    Run = 1'b0;
    n   = 0;
    while (Iter != 3'd4 && n < 50) begin
      tick();
      n++;
    end
    chk("reached_iter4", Iter, 32'd4);
    Reset_n = 1'b0;
    tick();
    chk("midop_rst_busy_iter", {Busy, Done, Iter}, 32'd0);
    chk("midop_rst_strobes", {Add, Sub, Shift_En}, 32'd0);
    Reset_n = 1'b1;
    tick();

    // Operand extremes.
    load_b(8'h80); start_mult(8'h80, 8'h80, 0, 1'b0);
    load_b(8'h7F); start_mult(8'h7F, 8'h7F, 0, 1'b0);
    load_b(8'h00); start_mult(8'hD7, 8'h00, 0, 1'b0);
    load_b(8'hFF); start_mult(8'h80, 8'hFF, 2, 1'b0);

    // Random operands and Run hold lengths.
    for (int i = 0; i < 12; i++) begin
      rs = 8'($urandom);
      rb = 8'($urandom);
      load_b(rb);
      start_mult(rs, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0, 1'b0);
    end

    tick();
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
